// File: rtl/yuv2rgb_pipe_if.sv
// Pixel stream bundle for yuv2rgb_pipe: YUV samples in, RGB samples out,
// each with its line-valid and frame-sync strobes.
interface yuv2rgb_pipe_if #(
  parameter int unsigned BITS = 8
);
  logic            in_href;
  logic            in_vsync;
  logic [BITS-1:0] in_y;
  logic [BITS-1:0] in_u;
  logic [BITS-1:0] in_v;
  logic            out_href;
  logic            out_vsync;
  logic [BITS-1:0] out_r;
  logic [BITS-1:0] out_g;
  logic [BITS-1:0] out_b;

  // Source side: drives YUV, observes RGB.
  modport master (
    output in_href, in_vsync, in_y, in_u, in_v,
    input  out_href, out_vsync, out_r, out_g, out_b
  );

  // Converter side.
  modport slave (
    input  in_href, in_vsync, in_y, in_u, in_v,
    output out_href, out_vsync, out_r, out_g, out_b
  );
endinterface

// File: rtl/yuv2rgb_pipe.sv
// YUV to RGB converter: BT.601/BT.709 limited or BT.601 full, 4:4:4 or
// interleaved 4:2:2 input, frame-synchronous config, fixed 6-cycle latency.
// Rank s0 samples the inputs; s1 pairs chroma, s2 removes offsets,
// s3 multiplies, s4 sums and rounds, s5 shifts, output rank clips.
module yuv2rgb_pipe #(
  parameter int unsigned BITS = 8
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic [1:0]    in_conv_standard,
  input  logic          in_fmt422,
  yuv2rgb_pipe_if.slave bus
);
  localparam int unsigned DW = BITS + 2;
  localparam int unsigned PW = BITS + 12;
  localparam int unsigned SW = BITS + 13;
  localparam logic [BITS-1:0]      COFF = BITS'(1 << (BITS - 1));
  localparam logic [BITS-1:0]      YOFF = BITS'(16 << (BITS - 8));
  localparam logic signed [SW-1:0] VMAX = SW'((1 << BITS) - 1);

  // Active (shadowed) configuration
  logic [1:0]             r_std;
  logic                   r_fmt;
  // Input sample rank
  logic                   r_s0_href, r_s0_vsync, r_s0_phase, r_s0_fmt;
  logic [1:0]             r_s0_std;
  logic [BITS-1:0]        r_s0_y, r_s0_u, r_s0_v;
  logic [BITS-1:0]        r_prev_u;
  logic                   r_phase;
  logic                   w_cur_phase;
  // Alignment rank
  logic [BITS-1:0]        w_cb, w_cr;
  logic [BITS-1:0]        r_s1_y, r_s1_cb, r_s1_cr;
  logic [1:0]             r_s1_std;
  // Offset rank
  logic [BITS-1:0]        w_yoff;
  logic signed [DW-1:0]   r_s2_y, r_s2_u, r_s2_v;
  logic [1:0]             r_s2_std;
  // Multiply rank
  logic signed [11:0]     w_ky, w_rv, w_gu, w_gv, w_bu;
  logic signed [PW-1:0]   r_s3_py, r_s3_prv, r_s3_pgu, r_s3_pgv, r_s3_pbu;
  // Sum and shift ranks
  logic signed [SW-1:0]   r_s4_r, r_s4_g, r_s4_b;
  logic signed [SW-1:0]   r_s5_r, r_s5_g, r_s5_b;
  // Strobe delay lines and outputs
  logic [5:0]             r_href_d, r_vsync_d;
  logic [BITS-1:0]        r_out_r, r_out_g, r_out_b;

  function automatic logic [BITS-1:0] clip(input logic signed [SW-1:0] v);
    if (v < 0)         return '0;
    else if (v > VMAX) return VMAX[BITS-1:0];
    else               return v[BITS-1:0];
  endfunction

  // Phase restarts at 0 on the first pixel of each line.
  assign w_cur_phase = r_s0_href ? r_phase : 1'b0;

  // Input sampling, config shadowing on vsync rise, 4:2:2 phase tracking
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_std      <= 2'd0;
      r_fmt      <= 1'b0;
      r_s0_href  <= 1'b0;
      r_s0_vsync <= 1'b0;
      r_s0_phase <= 1'b0;
      r_s0_fmt   <= 1'b0;
      r_s0_std   <= 2'd0;
      r_s0_y     <= '0;
      r_s0_u     <= '0;
      r_s0_v     <= '0;
      r_prev_u   <= '0;
      r_phase    <= 1'b0;
    end else begin
      if (bus.in_vsync && !r_s0_vsync) begin
        r_std <= (in_conv_standard == 2'd3) ? 2'd0 : in_conv_standard;
        r_fmt <= in_fmt422;
      end
      // The pixel sampled on the vsync-rise edge still carries the old config.
      r_s0_std   <= r_std;
      r_s0_fmt   <= r_fmt;
      r_s0_href  <= bus.in_href;
      r_s0_vsync <= bus.in_vsync;
      r_s0_phase <= w_cur_phase;
      r_s0_y     <= bus.in_y;
      r_s0_u     <= bus.in_u;
      r_s0_v     <= bus.in_v;
      r_prev_u   <= r_s0_u;
      if (bus.in_href) r_phase <= ~w_cur_phase;
    end
  end

  // Chroma pairing: even pixel borrows Cr from the live next sample.
  always_comb begin
    w_cb = r_s0_u;
    w_cr = r_s0_v;
    if (r_s0_fmt) begin
      if (!r_s0_phase) begin
        w_cr = bus.in_href ? bus.in_u : COFF;
      end else begin
        w_cb = r_prev_u;
        w_cr = r_s0_u;
      end
    end
  end

  // Y offset depends on range of the pixel's own standard
  always_comb begin
    w_yoff = (r_s1_std == 2'd2) ? '0 : YOFF;
  end

  // Coefficient table, x256
  always_comb begin
    w_ky = 12'sd298; w_rv = 12'sd409; w_gu = -12'sd100; w_gv = -12'sd208; w_bu = 12'sd516;
    case (r_s2_std)
      2'd1: begin
        w_ky = 12'sd298; w_rv = 12'sd459; w_gu = -12'sd55; w_gv = -12'sd136; w_bu = 12'sd541;
      end
      2'd2: begin
        w_ky = 12'sd256; w_rv = 12'sd359; w_gu = -12'sd88; w_gv = -12'sd183; w_bu = 12'sd454;
      end
      default: ;
    endcase
  end

  // Arithmetic ranks: align, offset, multiply, sum+round, shift
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_s1_y <= '0; r_s1_cb <= '0; r_s1_cr <= '0; r_s1_std <= 2'd0;
      r_s2_y <= '0; r_s2_u <= '0; r_s2_v <= '0; r_s2_std <= 2'd0;
      r_s3_py <= '0; r_s3_prv <= '0; r_s3_pgu <= '0; r_s3_pgv <= '0; r_s3_pbu <= '0;
      r_s4_r <= '0; r_s4_g <= '0; r_s4_b <= '0;
      r_s5_r <= '0; r_s5_g <= '0; r_s5_b <= '0;
    end else begin
      r_s1_y   <= r_s0_y;
      r_s1_cb  <= w_cb;
      r_s1_cr  <= w_cr;
      r_s1_std <= r_s0_std;

      r_s2_y   <= $signed({2'b00, r_s1_y})  - $signed({2'b00, w_yoff});
      r_s2_u   <= $signed({2'b00, r_s1_cb}) - $signed({2'b00, COFF});
      r_s2_v   <= $signed({2'b00, r_s1_cr}) - $signed({2'b00, COFF});
      r_s2_std <= r_s1_std;

      r_s3_py  <= PW'(r_s2_y) * PW'(w_ky);
      r_s3_prv <= PW'(r_s2_v) * PW'(w_rv);
      r_s3_pgu <= PW'(r_s2_u) * PW'(w_gu);
      r_s3_pgv <= PW'(r_s2_v) * PW'(w_gv);
      r_s3_pbu <= PW'(r_s2_u) * PW'(w_bu);

      r_s4_r <= SW'(r_s3_py) + SW'(r_s3_prv) + SW'(128);
      r_s4_g <= SW'(r_s3_py) + SW'(r_s3_pgu) + SW'(r_s3_pgv) + SW'(128);
      r_s4_b <= SW'(r_s3_py) + SW'(r_s3_pbu) + SW'(128);

      r_s5_r <= r_s4_r >>> 8;
      r_s5_g <= r_s4_g >>> 8;
      r_s5_b <= r_s4_b >>> 8;
    end
  end

  // Strobe delay lines and clipped, blanked output rank
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_href_d  <= '0;
      r_vsync_d <= '0;
      r_out_r   <= '0;
      r_out_g   <= '0;
      r_out_b   <= '0;
    end else begin
      r_href_d  <= {r_href_d[4:0], r_s0_href};
      r_vsync_d <= {r_vsync_d[4:0], r_s0_vsync};
      r_out_r   <= r_href_d[4] ? clip(r_s5_r) : '0;
      r_out_g   <= r_href_d[4] ? clip(r_s5_g) : '0;
      r_out_b   <= r_href_d[4] ? clip(r_s5_b) : '0;
    end
  end

  assign bus.out_href  = r_href_d[5];
  assign bus.out_vsync = r_vsync_d[5];
  assign bus.out_r     = r_out_r;
  assign bus.out_g     = r_out_g;
  assign bus.out_b     = r_out_b;
endmodule
